// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboard register file.
//   RF_DATA_W / RF_NUM_REGS / RF_NUM_RD : default width, depth and read-port count
//   rf_addr_ok(addr, n)                 : 1 when addr addresses one of n registers
// Optional feature macro used by the register file: REGFILE_BYPASS_EN.
package regfile_pkg;

   localparam int unsigned RF_DATA_W   = 8;
   localparam int unsigned RF_NUM_REGS = 4;
   localparam int unsigned RF_NUM_RD   = 2;

   function automatic logic rf_addr_ok(input logic [31:0] addr, input int unsigned n);
      return addr < n;
   endfunction

endpackage

// File: rtl/rf_read_port.sv
// One registered read port of the scoreboard register file.
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   regs_i, busy_i           flattened register contents and scoreboard vector
//   wr_en_i/wr_addr_i/...    in-range write of this cycle (forwarding source)
//   rsv_ready_i, rsv_addr_i  accepted reserve of this cycle
//   rd_en_i, rd_addr_i       read request
//   rd_data_o/rd_busy_o/rd_valid_o  registered read result
// Macro REGFILE_BYPASS_EN: forward a same-cycle write to the read result.
module rf_read_port import regfile_pkg::*; #(
   parameter int unsigned DATA_W   = RF_DATA_W,
   parameter int unsigned NUM_REGS = RF_NUM_REGS,
   parameter int unsigned ADDR_W   = $clog2(RF_NUM_REGS)
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [NUM_REGS*DATA_W-1:0] regs_i,
   input  logic [NUM_REGS-1:0]        busy_i,
   input  logic                       wr_en_i,
   input  logic [ADDR_W-1:0]          wr_addr_i,
   input  logic [DATA_W-1:0]          wr_data_i,
   input  logic                       rsv_ready_i,
   input  logic [ADDR_W-1:0]          rsv_addr_i,
   input  logic                       rd_en_i,
   input  logic [ADDR_W-1:0]          rd_addr_i,
   output logic [DATA_W-1:0]          rd_data_o,
   output logic                       rd_busy_o,
   output logic                       rd_valid_o
);

   logic [DATA_W-1:0] sel_data, data_d, data_q;
   logic              sel_busy, busy_d, busy_q;
   logic              valid_q;

   // Out-of-range addresses match no register and so read as zero / not busy.
   always_comb begin
      sel_data = '0;
      sel_busy = 1'b0;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
         if (rd_addr_i == ADDR_W'(r)) begin
            sel_data = regs_i[r*DATA_W +: DATA_W];
            sel_busy = busy_i[r];
         end
      end
   end

`ifdef REGFILE_BYPASS_EN
   // wr_en_i is already range-qualified by the top level.
   always_comb begin
      data_d = sel_data;
      busy_d = sel_busy;
      if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
         data_d = wr_data_i;
         busy_d = rsv_ready_i && (rsv_addr_i == rd_addr_i);
      end
   end
`else
   logic unused_bypass;
   assign unused_bypass = ^{wr_en_i, wr_addr_i, wr_data_i, rsv_ready_i, rsv_addr_i};

   always_comb begin
      data_d = sel_data;
      busy_d = sel_busy;
   end
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         data_q  <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= rd_en_i;
         if (rd_en_i) begin
            data_q <= data_d;
            busy_q <= busy_d;
         end
      end
   end

   assign rd_data_o  = data_q;
   assign rd_busy_o  = busy_q;
   assign rd_valid_o = valid_q;

endmodule

// File: rtl/scoreboard_regfile.sv
// Parametrised multi-port register file with a per-register busy scoreboard.
// Ports:
//   clk, reset (sync, active-low)
//   wr_en/wr_addr/wr_data     write; clears the busy bit of the target
//   rsv_en/rsv_addr/rsv_ready reserve handshake; sets the busy bit when accepted
//   rd_en/rd_addr             per-port read request, addresses packed ADDR_W per port
//   rd_data/rd_busy/rd_valid  registered per-port read results
//   busy                      registered scoreboard vector
// Macro REGFILE_BYPASS_EN: write-to-read forwarding in the read ports.
module scoreboard_regfile import regfile_pkg::*; #(
   parameter  int unsigned DATA_W   = RF_DATA_W,
   parameter  int unsigned NUM_REGS = RF_NUM_REGS,
   parameter  int unsigned NUM_RD   = RF_NUM_RD,
   localparam int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     rsv_en,
   input  logic [ADDR_W-1:0]        rsv_addr,
   output logic                     rsv_ready,
   input  logic [NUM_RD-1:0]        rd_en,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_valid,
   output logic [NUM_RD-1:0]        rd_busy,
   output logic [NUM_REGS-1:0]      busy
);

   logic [DATA_W-1:0]          regs_q [NUM_REGS];
   logic [DATA_W-1:0]          regs_d [NUM_REGS];
   logic [NUM_REGS-1:0]        busy_q, busy_d;
   logic [NUM_REGS*DATA_W-1:0] regs_flat;
   logic                       wr_ok, rsv_cur_busy;

   assign wr_ok = wr_en && rf_addr_ok(32'(wr_addr), NUM_REGS);

   always_comb begin
      rsv_cur_busy = 1'b0;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
         if (rsv_addr == ADDR_W'(r)) rsv_cur_busy = busy_q[r];
      end
   end

   assign rsv_ready = reset && rsv_en && rf_addr_ok(32'(rsv_addr), NUM_REGS) && !rsv_cur_busy;

   // Reserve is applied after the write so a same-cycle reserve leaves busy set.
   always_comb begin
      busy_d = busy_q;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
         regs_d[r] = regs_q[r];
         if (wr_ok && (wr_addr == ADDR_W'(r))) begin
            regs_d[r] = wr_data;
            busy_d[r] = 1'b0;
         end
         if (rsv_ready && (rsv_addr == ADDR_W'(r))) busy_d[r] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int unsigned r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
         busy_q <= '0;
      end else begin
         for (int unsigned r = 0; r < NUM_REGS; r++) regs_q[r] <= regs_d[r];
         busy_q <= busy_d;
      end
   end

   always_comb begin
      regs_flat = '0;
      for (int unsigned r = 0; r < NUM_REGS; r++) regs_flat[r*DATA_W +: DATA_W] = regs_q[r];
   end

   assign busy = busy_q;

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      rf_read_port #(
         .DATA_W   (DATA_W),
         .NUM_REGS (NUM_REGS),
         .ADDR_W   (ADDR_W)
      ) u_port (
         .clk_i       (clk),
         .rst_ni      (reset),
         .regs_i      (regs_flat),
         .busy_i      (busy_q),
         .wr_en_i     (wr_ok),
         .wr_addr_i   (wr_addr),
         .wr_data_i   (wr_data),
         .rsv_ready_i (rsv_ready),
         .rsv_addr_i  (rsv_addr),
         .rd_en_i     (rd_en[p]),
         .rd_addr_i   (rd_addr[p*ADDR_W +: ADDR_W]),
         .rd_data_o   (rd_data[p*DATA_W +: DATA_W]),
         .rd_busy_o   (rd_busy[p]),
         .rd_valid_o  (rd_valid[p])
      );
   end

endmodule
